// File: rtl/ibex_pkg.sv
// Shared Ibex types: interrupt vector layout, exception causes and the
// interrupt-controller FSM state.
package ibex_pkg;

    typedef struct packed {
        logic        irq_software;
        logic        irq_timer;
        logic        irq_external;
        logic [14:0] irq_fast;
    } irqs_t;

    typedef enum logic [5:0] {
        EXC_CAUSE_INSN_ADDR_MISA     = {1'b0, 5'd00},
        EXC_CAUSE_ILLEGAL_INSN       = {1'b0, 5'd02},
        EXC_CAUSE_BREAKPOINT         = {1'b0, 5'd03},
        EXC_CAUSE_ECALL_MMODE        = {1'b0, 5'd11},
        EXC_CAUSE_IRQ_SOFTWARE_M     = {1'b1, 5'd03},
        EXC_CAUSE_IRQ_TIMER_M        = {1'b1, 5'd07},
        EXC_CAUSE_IRQ_EXTERNAL_M     = {1'b1, 5'd11},
        EXC_CAUSE_IRQ_NM             = {1'b1, 5'd31}
    } exc_cause_e;

    typedef enum logic {IRQ_IDLE, IRQ_REQ} irq_ctrl_state_e;

    parameter logic [4:0] EXC_CAUSE_IRQ_FAST_BASE = 5'd16;

endpackage

// File: rtl/ibex_irq_sync.sv
// Two-flop synchroniser for a bundle of independent level signals.
module ibex_irq_sync #(
    parameter int unsigned Width = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [Width-1:0] d,
    output logic [Width-1:0] q
);

    logic [Width-1:0] meta;

    // NOTE: non-blocking assignments make meta->q a real two-stage shift;
    // blocking ones would collapse the chain into a single flop.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/ibex_irq_ctrl.sv
// Interrupt controller: synchronises and masks interrupt sources, picks the
// highest-priority one and holds it as a request until acked or withdrawn.
module ibex_irq_ctrl
    import ibex_pkg::*;
#(
    parameter bit SyncIrqs = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        irq_software_i,
    input  logic        irq_timer_i,
    input  logic        irq_external_i,
    input  logic [14:0] irq_fast_i,
    input  logic        irq_nm_i,
    input  logic [17:0] csr_mie_i,
    input  logic        csr_mstatus_mie_i,
    input  logic        debug_mode_i,
    input  logic        nmi_mode_i,
    output logic [17:0] csr_mip_o,
    output logic        irq_pending_o,
    output logic        irq_req_o,
    output logic [5:0]  irq_cause_o,
    output logic        irq_nm_o,
    input  logic        irq_ack_i
);

    typedef struct packed {
        logic       valid;
        logic       nm;
        logic [5:0] cause;
        irqs_t      src;
    } irq_sel_t;

    irqs_t           irqs_raw, mip, mie, lvl_cand, req_src_q;
    logic            nmi_level, nmi_level_q, nmi_edge, nmi_q, nmi_clr, nmi_cand;
    logic            src_live, withdraw;
    irq_sel_t        sel;
    irq_ctrl_state_e state_q;

    assign irqs_raw = irqs_t'({irq_software_i, irq_timer_i, irq_external_i, irq_fast_i});
    assign mie      = irqs_t'(csr_mie_i);

    if (SyncIrqs) begin : g_sync
        logic [18:0] sync_q;

        ibex_irq_sync #(.Width(19)) u_sync (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .d      ({irq_nm_i, irqs_raw}),
            .q      (sync_q)
        );

        assign mip       = irqs_t'(sync_q[17:0]);
        assign nmi_level = sync_q[18];
    end else begin : g_nosync
        assign mip       = irqs_raw;
        assign nmi_level = irq_nm_i;
    end

    assign csr_mip_o = mip;
    assign nmi_edge  = nmi_level & ~nmi_level_q;
    assign nmi_clr   = (state_q == IRQ_REQ) & irq_ack_i & irq_nm_o;

    // A new edge in the ack cycle must not be lost, so the set term dominates.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            nmi_level_q <= 1'b0;
            nmi_q       <= 1'b0;
        end else begin
            nmi_level_q <= nmi_level;
            nmi_q       <= nmi_edge | (nmi_q & ~nmi_clr);
        end
    end

    assign nmi_cand = (nmi_q | nmi_edge) & ~nmi_mode_i & ~debug_mode_i;
    assign lvl_cand = irqs_t'(mip & mie & {18{csr_mstatus_mie_i & ~debug_mode_i}});

    function automatic irq_sel_t irq_prio(input logic nmi, input irqs_t lvl);
        irq_sel_t s;
        // NOTE: full default first so every path assigns every field; no
        // partially-assigned result can leak out as held state.
        s = '0;
        if (nmi) begin
            s.valid = 1'b1;
            s.nm    = 1'b1;
            s.cause = EXC_CAUSE_IRQ_NM;
        end else if (lvl.irq_external) begin
            s.valid            = 1'b1;
            s.cause            = EXC_CAUSE_IRQ_EXTERNAL_M;
            s.src.irq_external = 1'b1;
        end else if (lvl.irq_software) begin
            s.valid            = 1'b1;
            s.cause            = EXC_CAUSE_IRQ_SOFTWARE_M;
            s.src.irq_software = 1'b1;
        end else if (lvl.irq_timer) begin
            s.valid         = 1'b1;
            s.cause         = EXC_CAUSE_IRQ_TIMER_M;
            s.src.irq_timer = 1'b1;
        end else begin
            // Scan downwards so the lowest-numbered fast interrupt wins.
            for (int i = 14; i >= 0; i--) begin
                if (lvl.irq_fast[i]) begin
                    s.valid    = 1'b1;
                    s.cause    = {1'b1, EXC_CAUSE_IRQ_FAST_BASE + 5'(i)};
                    s.src      = '0;
                    s.src.irq_fast[i] = 1'b1;
                end
            end
        end
        return s;
    endfunction

    assign sel = irq_prio(nmi_cand, lvl_cand);

    // A level request survives only while its own source stays pending and enabled.
    assign src_live = (|(req_src_q & mip & mie)) & csr_mstatus_mie_i;
    assign withdraw = debug_mode_i | (~irq_nm_o & ~src_live);

    assign irq_pending_o = (|(mip & mie)) | nmi_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IRQ_IDLE;
            irq_req_o   <= 1'b0;
            irq_nm_o    <= 1'b0;
            irq_cause_o <= 6'h00;
            req_src_q   <= '0;
        end else begin
            unique case (state_q)
                IRQ_IDLE: begin
                    if (sel.valid) begin
                        state_q     <= IRQ_REQ;
                        irq_req_o   <= 1'b1;
                        irq_nm_o    <= sel.nm;
                        irq_cause_o <= sel.cause;
                        req_src_q   <= sel.src;
                    end
                end
                IRQ_REQ: begin
                    if (irq_ack_i || withdraw) begin
                        state_q   <= IRQ_IDLE;
                        irq_req_o <= 1'b0;
                        irq_nm_o  <= 1'b0;
                        req_src_q <= '0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ibex_irq_ctrl.sv
// Self-checking bench for ibex_irq_ctrl with synchronised inputs: priority
// table plus directed multi-cycle sequences for ack, withdraw, NMI and reset.
module tb_ibex_irq_ctrl;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        irq_software_i = 1'b0, irq_timer_i = 1'b0, irq_external_i = 1'b0;
    logic [14:0] irq_fast_i = '0;
    logic        irq_nm_i = 1'b0;
    logic [17:0] csr_mie_i = '0;
    logic        csr_mstatus_mie_i = 1'b0;
    logic        debug_mode_i = 1'b0, nmi_mode_i = 1'b0, irq_ack_i = 1'b0;
    logic [17:0] csr_mip_o;
    logic        irq_pending_o, irq_req_o, irq_nm_o;
    logic [5:0]  irq_cause_o;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    ibex_irq_ctrl #(.SyncIrqs(1'b1)) dut (
        .clk_i             (clk),
        .rst_ni            (rst_ni),
        .irq_software_i    (irq_software_i),
        .irq_timer_i       (irq_timer_i),
        .irq_external_i    (irq_external_i),
        .irq_fast_i        (irq_fast_i),
        .irq_nm_i          (irq_nm_i),
        .csr_mie_i         (csr_mie_i),
        .csr_mstatus_mie_i (csr_mstatus_mie_i),
        .debug_mode_i      (debug_mode_i),
        .nmi_mode_i        (nmi_mode_i),
        .csr_mip_o         (csr_mip_o),
        .irq_pending_o     (irq_pending_o),
        .irq_req_o         (irq_req_o),
        .irq_cause_o       (irq_cause_o),
        .irq_nm_o          (irq_nm_o),
        .irq_ack_i         (irq_ack_i)
    );

    typedef struct {
        string       name;
        logic [17:0] irqs;
        logic [17:0] mie;
        logic        mstatus;
        logic        exp_req;
        logic [5:0]  exp_cause;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else
            n_pass++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_irqs(input logic [17:0] v);
        {irq_software_i, irq_timer_i, irq_external_i, irq_fast_i} = v;
    endtask

    task automatic nmi_pulse();
        irq_nm_i = 1'b1;
        step();
        irq_nm_i = 1'b0;
    endtask

    vec_t vecs[12];

    initial begin
        vecs[0]  = '{"timer",          18'h10000, 18'h3FFFF, 1'b1, 1'b1, 6'h27};
        vecs[1]  = '{"software",       18'h20000, 18'h3FFFF, 1'b1, 1'b1, 6'h23};
        vecs[2]  = '{"external",       18'h08000, 18'h3FFFF, 1'b1, 1'b1, 6'h2B};
        vecs[3]  = '{"all_pending",    18'h3FFFF, 18'h3FFFF, 1'b1, 1'b1, 6'h2B};
        vecs[4]  = '{"sw_over_timer",  18'h30000, 18'h3FFFF, 1'b1, 1'b1, 6'h23};
        vecs[5]  = '{"timer_over_f0",  18'h10001, 18'h3FFFF, 1'b1, 1'b1, 6'h27};
        vecs[6]  = '{"fast0",          18'h00001, 18'h3FFFF, 1'b1, 1'b1, 6'h30};
        vecs[7]  = '{"fast14",         18'h04000, 18'h3FFFF, 1'b1, 1'b1, 6'h3E};
        vecs[8]  = '{"fast5_over_9",   18'h00220, 18'h3FFFF, 1'b1, 1'b1, 6'h35};
        vecs[9]  = '{"ext_masked",     18'h18000, 18'h10000, 1'b1, 1'b1, 6'h27};
        vecs[10] = '{"mstatus_off",    18'h08000, 18'h3FFFF, 1'b0, 1'b0, 6'h00};
        vecs[11] = '{"mie_zero",       18'h3FFFF, 18'h00000, 1'b1, 1'b0, 6'h00};

        #12;
        check("reset_req",     {31'b0, irq_req_o},     32'd0);
        check("reset_cause",   {26'b0, irq_cause_o},   32'd0);
        check("reset_nm",      {31'b0, irq_nm_o},      32'd0);
        check("reset_mip",     {14'b0, csr_mip_o},     32'd0);
        check("reset_pending", {31'b0, irq_pending_o}, 32'd0);
        @(negedge clk);
        rst_ni = 1'b1;
        step();

        foreach (vecs[k]) begin
            set_irqs(vecs[k].irqs);
            csr_mie_i         = vecs[k].mie;
            csr_mstatus_mie_i = vecs[k].mstatus;
            step();
            step();
            step();
            check({vecs[k].name, "_req"}, {31'b0, irq_req_o}, {31'b0, vecs[k].exp_req});
            if (vecs[k].exp_req) begin
                check({vecs[k].name, "_cause"}, {26'b0, irq_cause_o}, {26'b0, vecs[k].exp_cause});
                check({vecs[k].name, "_nm"}, {31'b0, irq_nm_o}, 32'd0);
            end
            check({vecs[k].name, "_mip"}, {14'b0, csr_mip_o}, {14'b0, vecs[k].irqs});
            check({vecs[k].name, "_pending"}, {31'b0, irq_pending_o},
                  {31'b0, |(vecs[k].irqs & vecs[k].mie)});
            set_irqs('0);
            csr_mie_i         = '0;
            csr_mstatus_mie_i = 1'b0;
            irq_ack_i         = vecs[k].exp_req;
            step();
            irq_ack_i = 1'b0;
            step();
            step();
            step();
        end

        // Latency, ack, minimum idle, then withdraw by source drop.
        csr_mie_i         = 18'h3FFFF;
        csr_mstatus_mie_i = 1'b1;
        set_irqs(18'h10000);
        step();
        step();
        check("lat_early", {31'b0, irq_req_o}, 32'd0);
        step();
        check("lat_req",   {31'b0, irq_req_o}, 32'd1);
        check("lat_cause", {26'b0, irq_cause_o}, 32'h27);
        irq_ack_i = 1'b1;
        step();
        irq_ack_i = 1'b0;
        check("ack_drop", {31'b0, irq_req_o}, 32'd0);
        step();
        check("rearb_next", {31'b0, irq_req_o}, 32'd1);
        set_irqs('0);
        step();
        check("wd_hold1", {31'b0, irq_req_o}, 32'd1);
        step();
        check("wd_hold2", {31'b0, irq_req_o}, 32'd1);
        step();
        check("wd_drop", {31'b0, irq_req_o}, 32'd0);
        step();
        check("wd_stay", {31'b0, irq_req_o}, 32'd0);

        // Ack arriving in the withdraw cycle.
        set_irqs(18'h10000);
        step();
        step();
        step();
        check("wdack_req", {31'b0, irq_req_o}, 32'd1);
        set_irqs('0);
        step();
        step();
        check("wdack_hold", {31'b0, irq_req_o}, 32'd1);
        irq_ack_i = 1'b1;
        step();
        irq_ack_i = 1'b0;
        check("wdack_drop", {31'b0, irq_req_o}, 32'd0);
        step();
        step();
        check("wdack_stay", {31'b0, irq_req_o}, 32'd0);

        // External wins over fast[3]; fast[3] follows after one idle cycle.
        set_irqs(18'h08008);
        step();
        step();
        step();
        check("pri_req",   {31'b0, irq_req_o}, 32'd1);
        check("pri_cause", {26'b0, irq_cause_o}, 32'h2B);
        set_irqs(18'h00008);
        step();
        check("noprempt_cause", {26'b0, irq_cause_o}, 32'h2B);
        irq_ack_i = 1'b1;
        step();
        irq_ack_i = 1'b0;
        check("pri_ack_idle", {31'b0, irq_req_o}, 32'd0);
        step();
        check("fast3_req",   {31'b0, irq_req_o}, 32'd1);
        check("fast3_cause", {26'b0, irq_cause_o}, 32'h33);
        set_irqs('0);
        csr_mie_i = '0;
        irq_ack_i = 1'b1;
        step();
        irq_ack_i = 1'b0;
        step();
        step();
        step();

        // NMI pulse ignores mstatus.MIE.
        csr_mie_i         = 18'h3FFFF;
        csr_mstatus_mie_i = 1'b0;
        nmi_pulse();
        step();
        check("nmi_early", {31'b0, irq_req_o}, 32'd0);
        step();
        check("nmi_req",     {31'b0, irq_req_o},     32'd1);
        check("nmi_cause",   {26'b0, irq_cause_o},   32'h3F);
        check("nmi_flag",    {31'b0, irq_nm_o},      32'd1);
        check("nmi_pending", {31'b0, irq_pending_o}, 32'd1);
        irq_ack_i = 1'b1;
        step();
        irq_ack_i = 1'b0;
        check("nmi_ack_req", {31'b0, irq_req_o}, 32'd0);
        check("nmi_ack_nm",  {31'b0, irq_nm_o},  32'd0);
        step();
        check("nmi_cleared", {31'b0, irq_pending_o}, 32'd0);
        check("nmi_no_rereq", {31'b0, irq_req_o}, 32'd0);

        // NMI blocked by nmi_mode, then debug withdraw keeps the latch.
        nmi_mode_i = 1'b1;
        nmi_pulse();
        step();
        step();
        check("nmimode_noreq",   {31'b0, irq_req_o},     32'd0);
        check("nmimode_pending", {31'b0, irq_pending_o}, 32'd1);
        nmi_mode_i = 1'b0;
        step();
        check("nmimode_exit_req",   {31'b0, irq_req_o},   32'd1);
        check("nmimode_exit_cause", {26'b0, irq_cause_o}, 32'h3F);
        debug_mode_i = 1'b1;
        step();
        check("dbg_drop",    {31'b0, irq_req_o},     32'd0);
        check("dbg_latched", {31'b0, irq_pending_o}, 32'd1);
        debug_mode_i = 1'b0;
        step();
        check("dbg_exit_req", {31'b0, irq_req_o}, 32'd1);
        check("dbg_exit_nm",  {31'b0, irq_nm_o},  32'd1);
        irq_ack_i = 1'b1;
        step();
        irq_ack_i = 1'b0;
        step();
        check("dbg_done_pending", {31'b0, irq_pending_o}, 32'd0);

        // Async reset mid-request, then ack while idle.
        csr_mstatus_mie_i = 1'b1;
        set_irqs(18'h10000);
        step();
        step();
        step();
        check("rst_pre_req", {31'b0, irq_req_o}, 32'd1);
        #2;
        rst_ni = 1'b0;
        #1;
        check("rst_req",     {31'b0, irq_req_o},     32'd0);
        check("rst_cause",   {26'b0, irq_cause_o},   32'd0);
        check("rst_nm",      {31'b0, irq_nm_o},      32'd0);
        check("rst_mip",     {14'b0, csr_mip_o},     32'd0);
        check("rst_pending", {31'b0, irq_pending_o}, 32'd0);
        set_irqs('0);
        @(negedge clk);
        rst_ni = 1'b1;
        step();
        irq_ack_i = 1'b1;
        step();
        step();
        check("idle_ack_req",   {31'b0, irq_req_o},   32'd0);
        check("idle_ack_cause", {26'b0, irq_cause_o}, 32'd0);
        irq_ack_i = 1'b0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
